// File: rtl/adpll_seq_ctrl.sv
// ADPLL sequencing controller: programs the ADPLL over a simple bus master,
// polls for lock, then drives TX symbols onto data_mod_o while locked.

`ifndef FCWW
`define FCWW 20
`endif
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_DATA_W
`define ADPLL_DATA_W 32
`endif
`ifndef FCW
`define FCW 8'h00
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 8'h04
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 8'h08
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 8'h0C
`endif
`ifndef TX
`define TX 1'b1
`endif
`ifndef RX
`define RX 1'b0
`endif

module adpll_seq_ctrl #(
    parameter int unsigned FCW_W     = `FCWW,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned SYM_CYC   = 32,
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned MAX_POLLS = 1024,
    localparam int unsigned CH_W     = $clog2(N_CH),
    localparam int unsigned ADDR_W   = `ADPLL_ADDR_W,
    localparam int unsigned DATA_W   = `ADPLL_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_idx_i,
    input  logic [FCW_W-1:0]  cfg_fcw_i,
    input  logic              mode_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              hop_i,
    input  logic [CH_W-1:0]   chan_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wstrb_o,
    input  logic [1:0]        rdata_i,
    input  logic              ready_i,
    input  logic              tx_valid_i,
    input  logic              tx_data_i,
    output logic              tx_ready_o,
    output logic              data_mod_o,
    output logic              busy_o,
    output logic              locked_o,
    output logic              timeout_err_o,
    output logic              underrun_o
);

    localparam int unsigned POLL_W = $clog2(MAX_POLLS + 1);
    localparam int unsigned GAP_W  = $clog2(POLL_GAP) + 1;
    localparam int unsigned SYM_W  = $clog2(SYM_CYC);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_FCW  = 3'd1;
    localparam logic [2:0] S_WR_MODE = 3'd2;
    localparam logic [2:0] S_WR_EN   = 3'd3;
    localparam logic [2:0] S_RD_LOCK = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;
    localparam logic [2:0] S_LOCKED  = 3'd6;
    localparam logic [2:0] S_WR_DIS  = 3'd7;

    logic [FCW_W-1:0]  table_q [N_CH];

    logic [2:0]        state_q,     state_d;
    logic [CH_W-1:0]   chan_q,      chan_d;
    logic              mode_q,      mode_d;
    logic [FCW_W-1:0]  fcw_q,       fcw_d;
    logic [POLL_W-1:0] poll_q,      poll_d;
    logic [GAP_W-1:0]  gap_q,       gap_d;
    logic [SYM_W-1:0]  sym_q,       sym_d;
    logic              hop_pend_q,  hop_pend_d;
    logic              stop_pend_q, stop_pend_d;
    logic              valid_q,     valid_d;
    logic [ADDR_W-1:0] address_q,   address_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              wstrb_q,     wstrb_d;
    logic              tx_ready_q,  tx_ready_d;
    logic              data_mod_q,  data_mod_d;
    logic              busy_q,      busy_d;
    logic              locked_q,    locked_d;
    logic              timeout_q,   timeout_d;
    logic              underrun_q,  underrun_d;
    logic [POLL_W-1:0] poll_inc_c;

    assign poll_inc_c = poll_q + POLL_W'(1);

    // Channel table: writable in any state, contents survive reset
    always_ff @(posedge clk_i) begin
        if (cfg_we_i) begin
            table_q[cfg_idx_i] <= cfg_fcw_i;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        mode_d      = mode_q;
        fcw_d       = fcw_q;
        poll_d      = poll_q;
        gap_d       = gap_q;
        sym_d       = sym_q;
        hop_pend_d  = hop_pend_q;
        stop_pend_d = stop_pend_q;
        valid_d     = valid_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        timeout_d   = timeout_q;
        underrun_d  = underrun_q;
        data_mod_d  = data_mod_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_WR_FCW;
                    chan_d      = chan_i;
                    mode_d      = mode_i;
                    timeout_d   = 1'b0;
                    underrun_d  = 1'b0;
                    hop_pend_d  = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            S_WR_FCW, S_WR_MODE, S_WR_EN, S_RD_LOCK: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (!valid_q) begin
                    // No transaction outstanding: a stop can abort right away
                    if (stop_i || stop_pend_q) begin
                        state_d = S_WR_DIS;
                    end else begin
                        valid_d = 1'b1;
                        wstrb_d = 1'b1;
                        case (state_q)
                            S_WR_FCW: begin
                                address_d = ADDR_W'(`FCW);
                                wdata_d   = DATA_W'(fcw_q);
                            end
                            S_WR_MODE: begin
                                address_d = ADDR_W'(`ADPLL_MODE);
                                wdata_d   = DATA_W'(mode_q);
                            end
                            S_WR_EN: begin
                                address_d = ADDR_W'(`ADPLL_EN);
                                wdata_d   = DATA_W'(1);
                            end
                            default: begin
                                address_d = ADDR_W'(`ADPLL_LOCK);
                                wdata_d   = '0;
                                wstrb_d   = 1'b0;
                            end
                        endcase
                    end
                end else if (ready_i) begin
                    valid_d = 1'b0;
                    case (state_q)
                        S_WR_FCW:  state_d = S_WR_MODE;
                        S_WR_MODE: state_d = S_WR_EN;
                        S_WR_EN:   state_d = S_RD_LOCK;
                        default: begin
                            if (rdata_i == 2'd1) begin
                                state_d = S_LOCKED;
                            end else if (poll_inc_c == POLL_W'(MAX_POLLS)) begin
                                poll_d    = poll_inc_c;
                                timeout_d = 1'b1;
                                state_d   = S_WR_DIS;
                            end else begin
                                poll_d  = poll_inc_c;
                                gap_d   = '0;
                                state_d = S_GAP;
                            end
                        end
                    endcase
                    if (stop_i || stop_pend_q) begin
                        state_d = S_WR_DIS;
                    end
                end
            end
            S_GAP: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                    state_d     = S_WR_DIS;
                end else if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d = S_RD_LOCK;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_LOCKED: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                    state_d     = S_WR_DIS;
                end else if (hop_i) begin
                    chan_d     = chan_i;
                    hop_pend_d = 1'b1;
                    state_d    = S_WR_DIS;
                end else if (sym_q == SYM_W'(SYM_CYC - 1)) begin
                    sym_d = '0;
                end else begin
                    sym_d = sym_q + SYM_W'(1);
                end
            end
            default: begin
                // S_WR_DIS: always issue the disable write, then idle or re-lock
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (!valid_q) begin
                    valid_d   = 1'b1;
                    wstrb_d   = 1'b1;
                    address_d = ADDR_W'(`ADPLL_EN);
                    wdata_d   = '0;
                end else if (ready_i) begin
                    valid_d     = 1'b0;
                    hop_pend_d  = 1'b0;
                    stop_pend_d = 1'b0;
                    if (hop_pend_q && !stop_pend_q && !stop_i) begin
                        state_d = S_WR_FCW;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        // Channel entry is captured on entry so later table writes do not race the bus
        if (state_d == S_WR_FCW && state_q != S_WR_FCW) begin
            fcw_d  = table_q[chan_d];
            poll_d = '0;
        end
        if (state_d == S_LOCKED && state_q != S_LOCKED) begin
            poll_d = '0;
            sym_d  = '0;
        end

        // Symbol slot: take the source bit, or flag an underrun and send 0
        if (state_q == S_LOCKED && tx_ready_q) begin
            if (tx_valid_i) begin
                data_mod_d = tx_data_i;
            end else begin
                data_mod_d = 1'b0;
                underrun_d = 1'b1;
            end
        end
        if (state_d != S_LOCKED || mode_d != `TX) begin
            data_mod_d = 1'b0;
        end

        tx_ready_d = (state_d == S_LOCKED) && (mode_d == `TX) &&
                     (sym_d == SYM_W'(SYM_CYC - 1));
        busy_d     = (state_d != S_IDLE);
        locked_d   = (state_d == S_LOCKED);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            chan_q      <= '0;
            mode_q      <= 1'b0;
            fcw_q       <= '0;
            poll_q      <= '0;
            gap_q       <= '0;
            sym_q       <= '0;
            hop_pend_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 1'b0;
            tx_ready_q  <= 1'b0;
            data_mod_q  <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            mode_q      <= mode_d;
            fcw_q       <= fcw_d;
            poll_q      <= poll_d;
            gap_q       <= gap_d;
            sym_q       <= sym_d;
            hop_pend_q  <= hop_pend_d;
            stop_pend_q <= stop_pend_d;
            valid_q     <= valid_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            tx_ready_q  <= tx_ready_d;
            data_mod_q  <= data_mod_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
            underrun_q  <= underrun_d;
        end
    end

    assign valid_o       = valid_q;
    assign address_o     = address_q;
    assign wdata_o       = wdata_q;
    assign wstrb_o       = wstrb_q;
    assign tx_ready_o    = tx_ready_q;
    assign data_mod_o    = data_mod_q;
    assign busy_o        = busy_q;
    assign locked_o      = locked_q;
    assign timeout_err_o = timeout_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_adpll_seq_ctrl.sv
// Directed bench for adpll_seq_ctrl: bus responder plus a queue of expected
// bus transactions, TX symbol timing, hop/stop and reset behaviour.

`timescale 1ns/1ps

`ifndef FCWW
`define FCWW 20
`endif
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_DATA_W
`define ADPLL_DATA_W 32
`endif
`ifndef FCW
`define FCW 8'h00
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 8'h04
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 8'h08
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 8'h0C
`endif
`ifndef TX
`define TX 1'b1
`endif
`ifndef RX
`define RX 1'b0
`endif

module tb_adpll_seq_ctrl;

    localparam int POLL_GAP = 8;
    localparam int SYM_CYC  = 32;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        we;
    } txn_t;

    logic        clk;
    logic        rst_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_idx_i;
    logic [19:0] cfg_fcw_i;
    logic        mode_i;
    logic        start_i;
    logic        stop_i;
    logic        hop_i;
    logic [1:0]  chan_i;
    logic        valid_o;
    logic [7:0]  address_o;
    logic [31:0] wdata_o;
    logic        wstrb_o;
    logic [1:0]  rdata_i;
    logic        ready_i;
    logic        tx_valid_i;
    logic        tx_data_i;
    logic        tx_ready_o;
    logic        data_mod_o;
    logic        busy_o;
    logic        locked_o;
    logic        timeout_err_o;
    logic        underrun_o;

    int   checks;
    int   errors;
    int   cyc;
    int   rd_cnt;
    int   lock_at;
    int   last_rd;
    int   last_tr;
    int   n;
    logic seen;
    logic hold_ready;
    logic [7:0] cap_addr;
    logic any_txr;
    logic any_mod;
    txn_t exp_q[$];
    txn_t cur;

    adpll_seq_ctrl #(
        .FCW_W    (20),
        .N_CH     (4),
        .SYM_CYC  (SYM_CYC),
        .POLL_GAP (POLL_GAP),
        .MAX_POLLS(4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_fcw_i    (cfg_fcw_i),
        .mode_i       (mode_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .hop_i        (hop_i),
        .chan_i       (chan_i),
        .valid_o      (valid_o),
        .address_o    (address_o),
        .wdata_o      (wdata_o),
        .wstrb_o      (wstrb_o),
        .rdata_i      (rdata_i),
        .ready_i      (ready_i),
        .tx_valid_i   (tx_valid_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .data_mod_o   (data_mod_o),
        .busy_o       (busy_o),
        .locked_o     (locked_o),
        .timeout_err_o(timeout_err_o),
        .underrun_o   (underrun_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d, input logic w);
        txn_t t;
        t.addr = a;
        t.data = d;
        t.we   = w;
        exp_q.push_back(t);
    endtask

    // One clock; at the falling edge act as the bus slave and score transactions
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ready_i) begin
            ready_i = 1'b0;
            rdata_i = 2'd0;
            check("valid_drop", 32'(valid_o), 32'd0);
        end else if (valid_o && !hold_ready) begin
            if (!seen) begin
                seen     = 1'b1;
                cap_addr = address_o;
            end else begin
                seen    = 1'b0;
                ready_i = 1'b1;
                check("addr_stable", 32'(address_o), 32'(cap_addr));
                check("txn_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("txn_addr", 32'(address_o), 32'(cur.addr));
                    check("txn_wdata", wdata_o, cur.data);
                    check("txn_wstrb", 32'(wstrb_o), 32'(cur.we));
                end
                if (!wstrb_o) begin
                    if (last_rd >= 0) begin
                        check("rd_spacing", 32'((cyc - last_rd) >= POLL_GAP), 32'd1);
                    end
                    last_rd = cyc;
                    rd_cnt++;
                    rdata_i = (lock_at != 0 && rd_cnt == lock_at) ? 2'd1 : 2'd0;
                end
            end
        end
    endtask

    task automatic wait_locked(input int bound);
        n = 0;
        while (!locked_o && n < bound) begin
            tick();
            n++;
        end
        check("lock_reached", 32'(locked_o), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        n = 0;
        while (busy_o && n < bound) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy_o), 32'd0);
    endtask

    task automatic wait_tx_ready();
        n = 0;
        while (!tx_ready_o && n < 2 * SYM_CYC) begin
            tick();
            n++;
        end
        check("tx_ready_seen", 32'(tx_ready_o), 32'd1);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; rd_cnt = 0; lock_at = 0; last_rd = -1;
        seen = 1'b0; hold_ready = 1'b0; cap_addr = '0;
        rst_i = 1'b1; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_fcw_i = '0;
        mode_i = `TX; start_i = 1'b0; stop_i = 1'b0; hop_i = 1'b0; chan_i = '0;
        rdata_i = '0; ready_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_locked", 32'(locked_o), 32'd0);
        check("rst_addr", 32'(address_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_txready", 32'(tx_ready_o), 32'd0);
        check("rst_datamod", 32'(data_mod_o), 32'd0);
        check("rst_timeout", 32'(timeout_err_o), 32'd0);
        check("rst_underrun", 32'(underrun_o), 32'd0);
        rst_i = 1'b0;

        // Channel table
        cfg_we_i = 1'b1; cfg_idx_i = 2'd1; cfg_fcw_i = 20'h1E000; tick();
        cfg_idx_i = 2'd2; cfg_fcw_i = 20'h12345; tick();
        cfg_we_i = 1'b0;

        // Lock on the third read
        rd_cnt = 0; lock_at = 3; last_rd = -1;
        push(`FCW, 32'h1E000, 1'b1);
        push(`ADPLL_MODE, 32'(`TX), 1'b1);
        push(`ADPLL_EN, 32'd1, 1'b1);
        push(`ADPLL_LOCK, 32'd0, 1'b0);
        push(`ADPLL_LOCK, 32'd0, 1'b0);
        push(`ADPLL_LOCK, 32'd0, 1'b0);
        chan_i = 2'd1; mode_i = `TX; start_i = 1'b1; tick(); start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 32'd1);
        wait_locked(200);
        check("lock_reads", 32'(rd_cnt), 32'd3);
        check("lock_queue_empty", 32'(exp_q.size()), 32'd0);
        check("lock_busy", 32'(busy_o), 32'd1);

        // Alternating TX symbols, one per SYM_CYC cycles
        last_tr = -1;
        for (int k = 0; k < 4; k++) begin
            wait_tx_ready();
            if (last_tr >= 0) check("tx_period", 32'(cyc - last_tr), 32'(SYM_CYC));
            last_tr = cyc;
            tx_valid_i = 1'b1; tx_data_i = (k % 2) != 0;
            tick();
            check("data_mod_bit", 32'(data_mod_o), 32'(k % 2));
            check("tx_ready_pulse", 32'(tx_ready_o), 32'd0);
        end

        // Underrun: source has nothing on one slot
        wait_tx_ready();
        tx_valid_i = 1'b0;
        tick();
        check("underrun_mod", 32'(data_mod_o), 32'd0);
        check("underrun_set", 32'(underrun_o), 32'd1);
        wait_tx_ready();
        tx_valid_i = 1'b1; tx_data_i = 1'b1;
        tick();
        check("underrun_sticky", 32'(underrun_o), 32'd1);
        check("mod_after_underrun", 32'(data_mod_o), 32'd1);

        // Hop to channel 2: disable, reprogram, re-lock on first read
        rd_cnt = 0; lock_at = 1; last_rd = -1;
        push(`ADPLL_EN, 32'd0, 1'b1);
        push(`FCW, 32'h12345, 1'b1);
        push(`ADPLL_MODE, 32'(`TX), 1'b1);
        push(`ADPLL_EN, 32'd1, 1'b1);
        push(`ADPLL_LOCK, 32'd0, 1'b0);
        chan_i = 2'd2; hop_i = 1'b1; tick(); hop_i = 1'b0;
        check("hop_unlocked", 32'(locked_o), 32'd0);
        check("hop_mod_zero", 32'(data_mod_o), 32'd0);
        wait_locked(200);
        check("hop_queue_empty", 32'(exp_q.size()), 32'd0);

        // Hop and stop together: stop wins, single disable write
        push(`ADPLL_EN, 32'd0, 1'b1);
        hop_i = 1'b1; stop_i = 1'b1; tick(); hop_i = 1'b0; stop_i = 1'b0;
        wait_idle(50);
        for (int k = 0; k < 12; k++) tick();
        check("hopstop_queue_empty", 32'(exp_q.size()), 32'd0);
        check("hopstop_locked", 32'(locked_o), 32'd0);
        check("hopstop_busy", 32'(busy_o), 32'd0);
        check("underrun_still_sticky", 32'(underrun_o), 32'd1);

        // RX mode: no symbol strobes, modulation held low; then stop
        rd_cnt = 0; lock_at = 1; last_rd = -1;
        push(`FCW, 32'h1E000, 1'b1);
        push(`ADPLL_MODE, 32'(`RX), 1'b1);
        push(`ADPLL_EN, 32'd1, 1'b1);
        push(`ADPLL_LOCK, 32'd0, 1'b0);
        chan_i = 2'd1; mode_i = `RX; start_i = 1'b1; tick(); start_i = 1'b0;
        check("start_clears_underrun", 32'(underrun_o), 32'd0);
        wait_locked(200);
        any_txr = 1'b0; any_mod = 1'b0;
        for (int k = 0; k < SYM_CYC + 8; k++) begin
            tick();
            any_txr = any_txr | tx_ready_o;
            any_mod = any_mod | data_mod_o;
        end
        check("rx_no_tx_ready", 32'(any_txr), 32'd0);
        check("rx_no_mod", 32'(any_mod), 32'd0);
        push(`ADPLL_EN, 32'd0, 1'b1);
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        wait_idle(50);
        check("rx_stop_queue_empty", 32'(exp_q.size()), 32'd0);

        // Lock never comes: four reads, disable, timeout flagged
        rd_cnt = 0; lock_at = 0; last_rd = -1;
        push(`FCW, 32'h1E000, 1'b1);
        push(`ADPLL_MODE, 32'(`TX), 1'b1);
        push(`ADPLL_EN, 32'd1, 1'b1);
        for (int k = 0; k < 4; k++) push(`ADPLL_LOCK, 32'd0, 1'b0);
        push(`ADPLL_EN, 32'd0, 1'b1);
        chan_i = 2'd1; mode_i = `TX; start_i = 1'b1; tick(); start_i = 1'b0;
        wait_idle(400);
        check("timeout_set", 32'(timeout_err_o), 32'd1);
        check("timeout_reads", 32'(rd_cnt), 32'd4);
        check("timeout_queue_empty", 32'(exp_q.size()), 32'd0);
        check("timeout_locked", 32'(locked_o), 32'd0);

        // Reset while a transaction is stalled
        hold_ready = 1'b1;
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("start_clears_timeout", 32'(timeout_err_o), 32'd0);
        n = 0;
        while (!valid_o && n < 10) begin
            tick();
            n++;
        end
        check("stall_valid", 32'(valid_o), 32'd1);
        rst_i = 1'b1; tick();
        check("rst_mid_valid", 32'(valid_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_addr", 32'(address_o), 32'd0);
        check("rst_mid_wdata", wdata_o, 32'd0);
        check("rst_mid_wstrb", 32'(wstrb_o), 32'd0);
        check("rst_mid_locked", 32'(locked_o), 32'd0);
        rst_i = 1'b0; hold_ready = 1'b0; seen = 1'b0;
        exp_q.delete();
        tick(); tick();
        check("post_rst_idle", 32'(busy_o), 32'd0);
        check("post_rst_valid", 32'(valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adpll_seq_ctrl.md
ADPLL_SEQ_CTRL -- requirements
Module: adpll_seq_ctrl

Interface
REQ-001 SHALL have parameter FCW_W, default `FCWW, meaning FCW word width.
REQ-002 SHALL have parameter N_CH, default 4, meaning channel-table depth (power of 2, >=2); CH_W = clog2(N_CH).
REQ-003 SHALL have parameter SYM_CYC, default 32, meaning clk cycles per TX symbol (>=2).
REQ-004 SHALL have parameter POLL_GAP, default 8, meaning idle cycles between lock reads.
REQ-005 SHALL have parameter MAX_POLLS, default 1024, meaning lock reads before timeout.
REQ-006 SHALL have ports: clk in 1, 32 MHz clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports: cfg_we in 1; cfg_idx in CH_W; cfg_fcw in FCW_W, channel-table write.
REQ-008 SHALL have ports: mode in 1, `TX/`RX; start in 1; stop in 1; hop in 1; chan in CH_W, channel for start/hop.
REQ-009 SHALL have bus-master ports: valid out 1; address out `ADPLL_ADDR_W; wdata out `ADPLL_DATA_W; wstrb out 1; rdata in 2; ready in 1.
REQ-010 SHALL have ports: tx_valid in 1; tx_data in 1; tx_ready out 1, symbol source handshake; data_mod out 1.
REQ-011 SHALL have status outputs, each 1 bit: busy; locked; timeout_err (sticky); underrun (sticky).

Function
REQ-012 SHALL store N_CH FCW entries; cfg_we writes cfg_fcw to cfg_idx on the clock edge, in any state.
REQ-013 SHALL implement states IDLE, WR_FCW, WR_MODE, WR_EN, RD_LOCK, GAP, LOCKED, WR_DIS.
REQ-014 IDLE: start=1 -> latch chan and mode, enter WR_FCW; busy=0 only in IDLE.
REQ-015 WR_FCW writes table[latched chan] (zero-extended to `ADPLL_DATA_W) to `FCW; the entry is read on entering WR_FCW.
REQ-016 WR_MODE writes latched mode to `ADPLL_MODE; WR_EN writes 1 to `ADPLL_EN; WR_DIS writes 0 to `ADPLL_EN.
REQ-017 Bus handshake: valid, address, wdata and wstrb are held stable from assertion until the cycle ready=1 is sampled; valid drops the next cycle; valid is low for >=1 cycle between transactions.
REQ-018 wstrb=1 for writes and 0 for reads; wdata=0 during reads.
REQ-019 RD_LOCK reads `ADPLL_LOCK; rdata==1 on the ready cycle -> LOCKED; otherwise increment the poll counter and enter GAP for POLL_GAP cycles, then RD_LOCK.
REQ-020 When the poll counter reaches MAX_POLLS without lock, SHALL set timeout_err and enter WR_DIS, then IDLE.
REQ-021 locked=1 only in LOCKED; entering LOCKED clears the poll counter and symbol counter.
REQ-022 LOCKED, stop=1 -> WR_DIS -> IDLE; hop=1 -> latch chan, WR_DIS -> WR_FCW (full re-lock sequence); stop=1 and hop=1 together -> stop wins.
REQ-023 stop during WR_*/RD_LOCK/GAP SHALL complete the outstanding bus transaction, then WR_DIS -> IDLE; hop outside LOCKED and start outside IDLE are ignored.
REQ-024 TX, LOCKED with latched mode=`TX: symbol counter counts 0..SYM_CYC-1 and wraps; at count SYM_CYC-1, tx_ready=1 for that one cycle.
REQ-025 On a tx_ready cycle: tx_valid=1 -> data_mod<=tx_data the next edge; tx_valid=0 -> data_mod<=0 and underrun<=1.
REQ-026 data_mod SHALL be 0 outside LOCKED, in RX mode, and the cycle after leaving LOCKED; tx_ready=0 in RX mode.
REQ-027 timeout_err and underrun SHALL clear only on rst or on an accepted start.

Reset
REQ-028 On rst=1 at a clock edge: state IDLE; valid, wstrb, tx_ready, data_mod, busy, locked, timeout_err, underrun = 0; address, wdata = 0; counters = 0.
REQ-029 rst mid-transaction SHALL drop valid on the same edge without waiting for ready; channel table contents are not required to reset.

Verification
REQ-030 Table[1]=0x1E000, start, chan=1, mode=`TX, ready 1 cycle after valid, lock on the 3rd read -> writes `FCW=0x1E000, `ADPLL_MODE=`TX, `ADPLL_EN=1; 3 reads spaced >=POLL_GAP; locked=1.
REQ-031 Locked TX, tx_valid=1 with alternating bits -> tx_ready every 32 cycles exactly; data_mod changes 1 cycle after each tx_ready.
REQ-032 Locked TX, tx_valid held 0 for one symbol -> data_mod=0, underrun=1 and sticky until the next start.
REQ-033 rdata never 1, MAX_POLLS=4 -> exactly 4 lock reads, then `ADPLL_EN=0 write, timeout_err=1, busy=0.
REQ-034 Locked, hop=1 and stop=1 same cycle -> single `ADPLL_EN=0 write, IDLE, no `FCW write.
REQ-035 Locked, hop to chan=2 -> `ADPLL_EN=0, then `FCW=table[2], re-lock; rst asserted while valid=1 and ready=0 -> valid=0 next cycle, all outputs at reset values.
